id_stage_ctrl: RTL and testbench

Decode-stage controller that sequences the immediate generator and owns the ID/EX pipeline register. It derives ImmSrc from the opcode of the instruction held in ID, captures the returned ImmExt with PC and instruction into the EX-stage register, and runs valid/ready handshakes with fetch and execute. It also detects load-use hazards against the instruction in EX, inserts bubbles and applies branch flushes.

---
 rtl/id_stage_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_id_stage_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: drives the immediate-generator select from the
// opcode in ID, owns the ID/EX pipeline register, runs the fetch/execute
// valid-ready handshakes, and inserts load-use bubbles and branch flushes.
module id_stage_ctrl #(
    parameter int XLEN             = 64,
    parameter int LOAD_USE_BUBBLES = 1   // legal range 1..3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidD,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    output logic            ReadyD,
    output logic [2:0]      ImmSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            ReadyE,
    input  logic            FlushE,
    output logic            ValidE,
    output logic [31:0]     InstrE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic            IllegalE
);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Two bits are enough for the largest legal bubble count minus one.
    localparam int CNT_W = 2;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] count, next_count;

    logic illegal_d;
    logic use_rs1;
    logic use_rs2;
    logic zero_imm;
    logic hz;
    logic adv;
    logic load_e;
    logic kill_e;

    // funct3/funct7 do not influence any decision made in ID.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{InstrD[31:25], InstrD[14:12]};

    // Opcode decode: immediate select, illegal flag and source-register use.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ImmSrc    = 3'b111;
        illegal_d = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        zero_imm  = 1'b0;
        case (InstrD[6:0])
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
                ImmSrc    = 3'b000;
                illegal_d = 1'b0;
                use_rs1   = 1'b1;
            end
            OPC_STORE: begin
                ImmSrc    = 3'b001;
                illegal_d = 1'b0;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OPC_BRANCH: begin
                ImmSrc    = 3'b010;
                illegal_d = 1'b0;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                ImmSrc    = 3'b011;
                illegal_d = 1'b0;
            end
            OPC_JAL: begin
                ImmSrc    = 3'b100;
                illegal_d = 1'b0;
            end
            OPC_OP, OPC_OP_32: begin
                ImmSrc    = 3'b000;
                illegal_d = 1'b0;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                zero_imm  = 1'b1;
            end
            default: begin
                ImmSrc    = 3'b111;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Load-use hazard looks only at registered EX contents, so a bubble
    // (ValidE=0) can never re-trigger it.
    assign hz = ValidD && ValidE
             && (InstrE[6:0] == OPC_LOAD)
             && (InstrE[11:7] != 5'd0)
             && ((use_rs1 && (InstrD[19:15] == InstrE[11:7]))
              || (use_rs2 && (InstrD[24:20] == InstrE[11:7])));

    // The ID/EX register may be overwritten when EX drains it or it is empty.
    assign adv = ReadyE || !ValidE;

    // Control state register and bubble counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Next-state logic and handshake: flush beats hazard beats normal advance.
    always_comb begin
        next_state = state;
        next_count = count;
        ReadyD     = 1'b0;
        load_e     = 1'b0;
        kill_e     = 1'b0;
        case (state)
            RUN: begin
                if (FlushE) begin
                    kill_e = 1'b1;
                    ReadyD = 1'b1;
                end else if (adv && hz) begin
                    kill_e = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        next_count = CNT_W'(LOAD_USE_BUBBLES - 1);
                        next_state = BUBBLE;
                    end
                end else if (adv) begin
                    load_e = 1'b1;
                    ReadyD = 1'b1;
                end
            end
            BUBBLE: begin
                kill_e = 1'b1;
                if (FlushE) begin
                    next_count = '0;
                    next_state = RUN;
                    ReadyD     = 1'b1;
                end else begin
                    next_count = count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        next_state = RUN;
                    end
                end
            end
            default: begin
                next_state = RUN;
                next_count = '0;
            end
        endcase
    end

    // ID/EX pipeline register; OP/OP-32 carry no immediate, so store zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidE   <= 1'b0;
            InstrE   <= NOP_INSTR;
            PCE      <= '0;
            ImmExtE  <= '0;
            IllegalE <= 1'b0;
        end else if (kill_e) begin
            ValidE   <= 1'b0;
        end else if (load_e) begin
            ValidE   <= ValidD;
            InstrE   <= InstrD;
            PCE      <= PCD;
            ImmExtE  <= zero_imm ? '0 : ImmExt;
            IllegalE <= illegal_d;
        end
    end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed testbench for id_stage_ctrl. Two instances share the same stimulus:
// dut_a with one load-use bubble, dut_b with three.
module tb_id_stage_ctrl;

    localparam int XLEN = 64;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI  = 32'hFFF0_0093;  // addi x1,x0,-1
    localparam logic [31:0] JAL   = 32'h0080_006F;  // jal x0,+8
    localparam logic [31:0] LD5   = 32'h0000_B283;  // ld x5,0(x1)
    localparam logic [31:0] ADD5  = 32'h0022_8333;  // add x6,x5,x2
    localparam logic [31:0] LD0   = 32'h0000_B003;  // ld x0,0(x1)
    localparam logic [31:0] ADD0  = 32'h0020_0333;  // add x6,x0,x2

    // ImmSrc vectors: addi, jal, illegal, lui, sd, beq
    localparam logic [31:0]     VEC_INSTR [6] = '{32'hFFF00093, 32'h0080006F, 32'h0000007F,
                                                  32'h123450B7, 32'h0020B423, 32'h00208863};
    localparam logic [2:0]      VEC_SRC   [6] = '{3'b000, 3'b100, 3'b111, 3'b011, 3'b001, 3'b010};
    localparam logic [XLEN-1:0] VEC_IMM   [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd8, 64'd0,
                                                  64'h0000_0000_1234_5000, 64'd8, 64'd16};
    localparam logic            VEC_ILL   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic            clk;
    logic            rst_n;
    logic            ValidD;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] ImmExt;
    logic            ReadyE;
    logic            FlushE;

    logic            ReadyD_a, ValidE_a, IllegalE_a;
    logic [2:0]      ImmSrc_a;
    logic [31:0]     InstrE_a;
    logic [XLEN-1:0] PCE_a, ImmExtE_a;

    logic            ReadyD_b, ValidE_b, IllegalE_b;
    logic [2:0]      ImmSrc_b;
    logic [31:0]     InstrE_b;
    logic [XLEN-1:0] PCE_b, ImmExtE_b;

    int total = 0;
    int bad   = 0;

    id_stage_ctrl #(.XLEN(XLEN), .LOAD_USE_BUBBLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD),
        .ReadyD(ReadyD_a), .ImmSrc(ImmSrc_a), .ImmExt(ImmExt), .ReadyE(ReadyE),
        .FlushE(FlushE), .ValidE(ValidE_a), .InstrE(InstrE_a), .PCE(PCE_a),
        .ImmExtE(ImmExtE_a), .IllegalE(IllegalE_a)
    );

    id_stage_ctrl #(.XLEN(XLEN), .LOAD_USE_BUBBLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD),
        .ReadyD(ReadyD_b), .ImmSrc(ImmSrc_b), .ImmExt(ImmExt), .ReadyE(ReadyE),
        .FlushE(FlushE), .ValidE(ValidE_b), .InstrE(InstrE_b), .PCE(PCE_b),
        .ImmExtE(ImmExtE_b), .IllegalE(IllegalE_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference immediate generator, fed by dut_a's select (same-cycle path).
    always_comb begin
        case (ImmSrc_a)
            3'b000:  ImmExt = {{52{InstrD[31]}}, InstrD[31:20]};
            3'b001:  ImmExt = {{52{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            3'b010:  ImmExt = {{51{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            3'b011:  ImmExt = {{32{InstrD[31]}}, InstrD[31:12], 12'b0};
            3'b100:  ImmExt = {{43{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: ImmExt = '0;
        endcase
    end

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [XLEN-1:0] pc);
        ValidD = v;
        InstrD = instr;
        PCD    = pc;
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ValidD = 1'b0;
        InstrD = NOP;
        PCD    = '0;
        ReadyE = 1'b1;
        FlushE = 1'b0;
        tick();
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ValidE_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a got=%0b want=0", ValidE_a); end
        total++; if (ValidE_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b got=%0b want=0", ValidE_b); end
        total++; if (InstrE_a !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", InstrE_a, NOP); end
        total++; if (PCE_a !== '0) begin bad++; $display("FAIL reset_pc got=%h want=0", PCE_a); end
        total++; if (ImmExtE_a !== '0) begin bad++; $display("FAIL reset_imm got=%h want=0", ImmExtE_a); end
        total++; if (IllegalE_a !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b want=0", IllegalE_a); end
        // Mid-stream: load an ADDI, then assert reset between clock edges.
        drive(1'b1, ADDI, 64'h40);
        tick();
        total++; if (ValidE_a !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%0b want=1", ValidE_a); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ValidE_a !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", ValidE_a); end
        total++; if (InstrE_a !== NOP) begin bad++; $display("FAIL midrst_instr got=%h want=%h", InstrE_a, NOP); end
        total++; if (PCE_a !== '0) begin bad++; $display("FAIL midrst_pc got=%h want=0", PCE_a); end
        ValidD = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_imm_src();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, VEC_INSTR[i], 64'h1000 + 64'(4 * i));
            total++; if (ImmSrc_a !== VEC_SRC[i]) begin bad++; $display("FAIL immsrc_a[%0d] got=%b want=%b", i, ImmSrc_a, VEC_SRC[i]); end
            total++; if (ImmSrc_b !== VEC_SRC[i]) begin bad++; $display("FAIL immsrc_b[%0d] got=%b want=%b", i, ImmSrc_b, VEC_SRC[i]); end
            total++; if (ReadyD_a !== 1'b1) begin bad++; $display("FAIL immsrc_ready[%0d] got=%0b want=1", i, ReadyD_a); end
            tick();
            total++; if (ValidE_a !== 1'b1) begin bad++; $display("FAIL immsrc_valid[%0d] got=%0b want=1", i, ValidE_a); end
            total++; if (ImmExtE_a !== VEC_IMM[i]) begin bad++; $display("FAIL immext[%0d] got=%h want=%h", i, ImmExtE_a, VEC_IMM[i]); end
            total++; if (IllegalE_a !== VEC_ILL[i]) begin bad++; $display("FAIL illegal_a[%0d] got=%0b want=%0b", i, IllegalE_a, VEC_ILL[i]); end
            total++; if (IllegalE_b !== VEC_ILL[i]) begin bad++; $display("FAIL illegal_b[%0d] got=%0b want=%0b", i, IllegalE_b, VEC_ILL[i]); end
            total++; if (PCE_b !== 64'h1000 + 64'(4 * i)) begin bad++; $display("FAIL immsrc_pc[%0d] got=%h want=%h", i, PCE_b, 64'h1000 + 64'(4 * i)); end
            total++; if (ImmExtE_b !== VEC_IMM[i]) begin bad++; $display("FAIL immext_b[%0d] got=%h want=%h", i, ImmExtE_b, VEC_IMM[i]); end
        end
    endtask

    task automatic test_load_use_1();
        do_reset();
        drive(1'b1, LD5, 64'h200);
        tick();
        drive(1'b1, ADD5, 64'h204);
        total++; if (ReadyD_a !== 1'b0) begin bad++; $display("FAIL lu1_hz_ready got=%0b want=0", ReadyD_a); end
        tick();
        total++; if (ValidE_a !== 1'b0) begin bad++; $display("FAIL lu1_bubble_valid got=%0b want=0", ValidE_a); end
        total++; if (ReadyD_a !== 1'b1) begin bad++; $display("FAIL lu1_after_ready got=%0b want=1", ReadyD_a); end
        tick();
        total++; if (ValidE_a !== 1'b1 || InstrE_a !== ADD5) begin bad++; $display("FAIL lu1_add_in_ex got=%0b/%h want=1/%h", ValidE_a, InstrE_a, ADD5); end
        total++; if (ImmExtE_a !== '0) begin bad++; $display("FAIL lu1_add_imm got=%h want=0", ImmExtE_a); end
        // Destination x0 never creates a hazard.
        do_reset();
        drive(1'b1, LD0, 64'h300);
        tick();
        drive(1'b1, ADD0, 64'h304);
        total++; if (ReadyD_a !== 1'b1) begin bad++; $display("FAIL lu1_x0_ready got=%0b want=1", ReadyD_a); end
        tick();
        total++; if (ValidE_a !== 1'b1 || InstrE_a !== ADD0) begin bad++; $display("FAIL lu1_x0_ex got=%0b/%h want=1/%h", ValidE_a, InstrE_a, ADD0); end
    endtask

    task automatic test_load_use_3();
        int  bubbles;
        logic seen;
        do_reset();
        drive(1'b1, LD5, 64'h200);
        tick();
        drive(1'b1, ADD5, 64'h204);
        total++; if (ReadyD_b !== 1'b0) begin bad++; $display("FAIL lu3_hz_ready got=%0b want=0", ReadyD_b); end
        bubbles = 0;
        seen    = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (ValidE_b === 1'b1 && InstrE_b === ADD5) seen = 1'b1;
            else if (ValidE_b === 1'b0) bubbles++;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL lu3_timeout got=%0b want=1", seen); end
        total++; if (bubbles != 3) begin bad++; $display("FAIL lu3_bubbles got=%0d want=3", bubbles); end
    endtask

    task automatic test_flush();
        // Flush while dut_b is in its bubble window.
        do_reset();
        drive(1'b1, LD5, 64'h200);
        tick();
        drive(1'b1, ADD5, 64'h204);
        total++; if (ReadyD_b !== 1'b0) begin bad++; $display("FAIL flb_hz_ready got=%0b want=0", ReadyD_b); end
        tick();
        total++; if (ReadyD_b !== 1'b0) begin bad++; $display("FAIL flb_bubble_ready got=%0b want=0", ReadyD_b); end
        FlushE = 1'b1;
        #1;
        total++; if (ReadyD_b !== 1'b1) begin bad++; $display("FAIL flb_flush_ready got=%0b want=1", ReadyD_b); end
        tick();
        FlushE = 1'b0;
        total++; if (ValidE_b !== 1'b0) begin bad++; $display("FAIL flb_valid got=%0b want=0", ValidE_b); end
        drive(1'b1, ADDI, 64'h800);
        total++; if (ReadyD_b !== 1'b1) begin bad++; $display("FAIL flb_next_ready got=%0b want=1", ReadyD_b); end
        tick();
        total++; if (ValidE_b !== 1'b1 || InstrE_b !== ADDI) begin bad++; $display("FAIL flb_next_ex got=%0b/%h want=1/%h", ValidE_b, InstrE_b, ADDI); end
        total++; if (PCE_b !== 64'h800) begin bad++; $display("FAIL flb_next_pc got=%h want=800", PCE_b); end
        // Flush in the same cycle as a hazard: flush wins, no bubble state.
        do_reset();
        drive(1'b1, LD5, 64'h200);
        tick();
        FlushE = 1'b1;
        drive(1'b1, ADD5, 64'h204);
        total++; if (ReadyD_b !== 1'b1) begin bad++; $display("FAIL flhz_ready_b got=%0b want=1", ReadyD_b); end
        total++; if (ReadyD_a !== 1'b1) begin bad++; $display("FAIL flhz_ready_a got=%0b want=1", ReadyD_a); end
        tick();
        FlushE = 1'b0;
        total++; if (ValidE_b !== 1'b0) begin bad++; $display("FAIL flhz_valid got=%0b want=0", ValidE_b); end
        drive(1'b1, ADDI, 64'h900);
        total++; if (ReadyD_b !== 1'b1) begin bad++; $display("FAIL flhz_run_ready got=%0b want=1", ReadyD_b); end
        tick();
        total++; if (ValidE_b !== 1'b1 || InstrE_b !== ADDI) begin bad++; $display("FAIL flhz_next_ex got=%0b/%h want=1/%h", ValidE_b, InstrE_b, ADDI); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, ADDI, 64'h100);
        tick();
        total++; if (ValidE_a !== 1'b1 || InstrE_a !== ADDI) begin bad++; $display("FAIL bp_load got=%0b/%h want=1/%h", ValidE_a, InstrE_a, ADDI); end
        ReadyE = 1'b0;
        drive(1'b1, JAL, 64'h104);
        for (int i = 0; i < 4; i++) begin
            total++; if (ReadyD_a !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%0b want=0", i, ReadyD_a); end
            tick();
            total++; if (ValidE_a !== 1'b1 || InstrE_a !== ADDI) begin bad++; $display("FAIL bp_instr[%0d] got=%0b/%h want=1/%h", i, ValidE_a, InstrE_a, ADDI); end
            total++; if (PCE_a !== 64'h100) begin bad++; $display("FAIL bp_pc[%0d] got=%h want=100", i, PCE_a); end
            total++; if (ImmExtE_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL bp_imm[%0d] got=%h want=ffffffffffffffff", i, ImmExtE_a); end
        end
        ReadyE = 1'b1;
        #1;
        total++; if (ReadyD_a !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", ReadyD_a); end
        tick();
        total++; if (InstrE_a !== JAL || PCE_a !== 64'h104) begin bad++; $display("FAIL bp_next got=%h/%h want=%h/104", InstrE_a, PCE_a, JAL); end
        total++; if (ImmExtE_a !== 64'd8) begin bad++; $display("FAIL bp_next_imm got=%h want=8", ImmExtE_a); end
    endtask

    initial begin
        rst_n  = 1'b0;
        ValidD = 1'b0;
        InstrD = NOP;
        PCD    = '0;
        ReadyE = 1'b1;
        FlushE = 1'b0;
        test_reset();
        test_imm_src();
        test_load_use_1();
        test_load_use_3();
        test_flush();
        test_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
